i2s_audio_out: RTL and testbench

//  Output stage directly downstream of the sound mixer. Accepts 16-bit signed mono samples
//  on a 96 kHz strobe, buffers them in a small FIFO, and serializes each sample to both

---
 rtl/i2s_audio_out.sv | 189 ++++++++++++++++++
 tb/tb_i2s_audio_out.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_out.sv
// ---------------------------------------------------------------------------
// i2s_audio_out
//   Output stage behind the sound mixer. Mono 16-bit signed samples arrive on
//   a 96 kHz push strobe, sit in a small FIFO, and each one is sent on both
//   channels of a Philips I2S stream (one BCLK of delay after the LRCK edge).
//
// Parameters
//   BCLK_DIV    CLK_AUDIO cycles per BCLK period (even, >= 2)
//   FIFO_DEPTH  sample FIFO entries (power of two, >= 2)
//
// Ports
//   CLK_AUDIO     in   audio clock, single domain
//   RESET_N       in   asynchronous active-low reset
//   SAMPLE_IN     in   16-bit signed sample from the mixer
//   SAMPLE_VALID  in   1-cycle push strobe
//   MUTE          in   popped samples are transmitted as zero while high
//   CLEAR_FLAGS   in   1-cycle pulse clearing OVERFLOW / UNDERFLOW
//   I2S_BCLK      out  bit clock (registered)
//   I2S_LRCK      out  word select, 0 = left, 1 = right (registered)
//   I2S_DATA      out  serial data, MSB first (registered)
//   FIFO_LEVEL    out  entries currently stored (registered)
//   OVERFLOW      out  sticky: a push was dropped
//   UNDERFLOW     out  sticky: a pop found the FIFO empty
//
// Push interface: SAMPLE_VALID is a strobe with no ready. A push is accepted
// whenever the FIFO has room, or when it is full but an entry leaves in the
// same cycle; otherwise the sample is dropped and OVERFLOW is set.
// ---------------------------------------------------------------------------
module i2s_audio_out #(
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK_AUDIO,
    input  logic                        RESET_N,
    input  logic [15:0]                 SAMPLE_IN,
    input  logic                        SAMPLE_VALID,
    input  logic                        MUTE,
    input  logic                        CLEAR_FLAGS,
    output logic                        I2S_BCLK,
    output logic                        I2S_LRCK,
    output logic                        I2S_DATA,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    output logic                        OVERFLOW,
    output logic                        UNDERFLOW
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    // Registered state
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [4:0]    slot_q, slot_d;
    logic          bclk_q, bclk_d;
    logic          lrck_q, lrck_d;
    logic          data_q, data_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [15:0]   mem_d [FIFO_DEPTH];
    logic [15:0]   last_sample_q, last_sample_d;
    logic [15:0]   tx_word_q, tx_word_d;
    logic          prev_lsb_q, prev_lsb_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    // Combinational helpers
    logic          tick;
    logic          pop_tick;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;
    logic [15:0]   head;
    logic [15:0]   word_sel;
    logic [15:0]   tx_sel;
    logic [3:0]    bit_idx;

    always_comb begin
        // Bit-clock divider; tick marks the BCLK falling edge.
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
        // BCLK is registered from the next divider value so it lines up with
        // div_cnt_q: the falling edge coincides with the tick update below.
        bclk_d    = (div_cnt_d >= DIV_HALF);
        slot_d    = tick ? slot_q + 5'd1 : slot_q;

        // One pop per frame, on the tick that enters slot 1.
        pop_tick   = tick && (slot_q == 5'd0);
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_FULL);
        pop        = pop_tick && !fifo_empty;
        push_ok    = SAMPLE_VALID && (!fifo_full || pop);

        head     = mem_q[rd_ptr_q];
        // Empty FIFO at pop time repeats the last real sample.
        word_sel = fifo_empty ? last_sample_q : head;
        tx_sel   = MUTE ? 16'h0000 : word_sel;

        // FIFO bookkeeping
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = SAMPLE_IN;
        end
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        last_sample_d = pop ? head : last_sample_q;
        tx_word_d     = pop_tick ? tx_sel : tx_word_q;
        // Right-channel LSB goes out in slot 0 of the following frame.
        prev_lsb_d    = (tick && (slot_q == 5'd16)) ? tx_word_q[0] : prev_lsb_q;

        // Slots 2..16 carry bits 14..0 and slots 17..31 carry bits 15..1;
        // both reduce to bit index (-slot) mod 16.
        bit_idx = 4'd0 - slot_d[3:0];

        lrck_d = lrck_q;
        data_d = data_q;
        if (tick) begin
            lrck_d = slot_d[4];
            if (slot_d == 5'd0) begin
                data_d = prev_lsb_q;
            end else if (slot_d == 5'd1) begin
                // tx_word_q is loaded on this same edge, so use the new word.
                data_d = tx_sel[15];
            end else begin
                data_d = tx_word_q[bit_idx];
            end
        end

        // Sticky flags: a set event beats a simultaneous clear.
        ovf_d = (SAMPLE_VALID && !push_ok) || (ovf_q && !CLEAR_FLAGS);
        unf_d = (pop_tick && fifo_empty) || (unf_q && !CLEAR_FLAGS);
    end

    always_ff @(posedge CLK_AUDIO or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt_q     <= '0;
            slot_q        <= '0;
            bclk_q        <= 1'b0;
            lrck_q        <= 1'b0;
            data_q        <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_sample_q <= '0;
            tx_word_q     <= '0;
            prev_lsb_q    <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            slot_q        <= slot_d;
            bclk_q        <= bclk_d;
            lrck_q        <= lrck_d;
            data_q        <= data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            mem_q         <= mem_d;
            last_sample_q <= last_sample_d;
            tx_word_q     <= tx_word_d;
            prev_lsb_q    <= prev_lsb_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
        end
    end

    assign I2S_BCLK   = bclk_q;
    assign I2S_LRCK   = lrck_q;
    assign I2S_DATA   = data_q;
    assign FIFO_LEVEL = level_q;
    assign OVERFLOW   = ovf_q;
    assign UNDERFLOW  = unf_q;

endmodule

// File: tb/tb_i2s_audio_out.sv
// ---------------------------------------------------------------------------
// tb_i2s_audio_out
//   Bench for i2s_audio_out with BCLK_DIV = 8 and FIFO_DEPTH = 4.
//   A cycle-level reference model (sample queue + frame arithmetic) predicts
//   every output after every clock edge; directed frame vectors and
//   hand-written sequences decode the serial stream back into words.
// ---------------------------------------------------------------------------
module tb_i2s_audio_out;

    localparam int DEPTH = 4;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b1;
    logic [15:0] sample_in    = 16'h0000;
    logic        sample_valid = 1'b0;
    logic        mute         = 1'b0;
    logic        clear_flags  = 1'b0;
    logic        bclk;
    logic        lrck;
    logic        sdata;
    logic [2:0]  level;
    logic        ovf;
    logic        unf;

    int total = 0;
    int bad   = 0;

    i2s_audio_out #(.BCLK_DIV(8), .FIFO_DEPTH(DEPTH)) dut (
        .CLK_AUDIO   (clk),
        .RESET_N     (rst_n),
        .SAMPLE_IN   (sample_in),
        .SAMPLE_VALID(sample_valid),
        .MUTE        (mute),
        .CLEAR_FLAGS (clear_flags),
        .I2S_BCLK    (bclk),
        .I2S_LRCK    (lrck),
        .I2S_DATA    (sdata),
        .FIFO_LEVEL  (level),
        .OVERFLOW    (ovf),
        .UNDERFLOW   (unf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // cyc = number of clock edges since reset release. Frame = 256 clocks,
    // slot = cyc/8 mod 32, pop happens on the edge where cyc mod 256 == 8.
    int          cyc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m_word = 16'h0000;   // word on the wire this frame
    logic [15:0] m_last = 16'h0000;   // last real sample popped
    logic        m_ovf  = 1'b0;
    logic        m_unf  = 1'b0;

    always @(posedge clk) begin : model
        logic        rn, v, mt, cl, pe, so, su;
        logic [15:0] d, w;
        int          n, ph, slot;
        logic        e_bclk, e_lrck, e_data;
        logic [7:0]  e_all, a_all;

        rn = rst_n; v = sample_valid; d = sample_in; mt = mute; cl = clear_flags;
        if (!rn) begin
            cyc = 0;
            exp_q.delete();
            m_word = 16'h0000;
            m_last = 16'h0000;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            cyc++;
            n  = exp_q.size();
            pe = (cyc % 256 == 8);
            so = 1'b0;
            su = 1'b0;
            if (pe) begin
                if (n > 0) begin
                    w = exp_q.pop_front();
                    m_last = w;
                end else begin
                    w = m_last;
                    su = 1'b1;
                end
                m_word = mt ? 16'h0000 : w;
            end
            if (v) begin
                if (n < DEPTH || (pe && n > 0)) exp_q.push_back(d);
                else so = 1'b1;
            end
            m_ovf = so | (m_ovf & ~cl);
            m_unf = su | (m_unf & ~cl);
        end
        #1;
        if (!rn) begin
            e_all = 8'h00;
        end else begin
            ph     = cyc % 256;
            slot   = ph / 8;
            e_bclk = ((cyc % 8) >= 4);
            e_lrck = (slot >= 16);
            if (slot == 0)       e_data = m_word[0];
            else if (slot <= 16) e_data = m_word[16 - slot];
            else                 e_data = m_word[32 - slot];
            e_all = {e_bclk, e_lrck, e_data, 3'(exp_q.size()), m_ovf, m_unf};
        end
        a_all = {bclk, lrck, sdata, level, ovf, unf};
        check("cycle{bclk,lrck,data,level,ovf,unf}", 32'(a_all), 32'(e_all));
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ph(input int p);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            @(negedge clk);
            if (cyc % 256 == p) hit = 1'b1;
        end
        check("wait_phase", 32'(hit), 32'd1);
    endtask

    task automatic wait_abs(input int t);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (cyc == t) hit = 1'b1;
        end
        check("wait_cycle", 32'(hit), 32'd1);
    endtask

    task automatic push(input logic [15:0] d);
        sample_in    = d;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
    endtask

    // Called right after a pop edge; samples DATA at each BCLK rising edge
    // for one frame and returns just after the next pop edge.
    task automatic decode_frame(output logic [15:0] left, output logic [15:0] right);
        logic [31:0] bits;
        bits  = 32'h0;
        left  = 16'h0;
        right = 16'h0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (cyc % 8 == 4) bits[(cyc % 256) / 8] = sdata;
        end
        for (int i = 0; i < 16; i++) left[15 - i] = bits[1 + i];
        for (int i = 0; i < 15; i++) right[15 - i] = bits[17 + i];
        right[0] = bits[0];
    endtask

    task automatic expect_frame(input string name, input logic [15:0] w);
        logic [15:0] l, r;
        decode_frame(l, r);
        check({name, "_left"}, 32'(l), 32'(w));
        check({name, "_right"}, 32'(r), 32'(w));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [15:0] sample;
        logic        mute;
        logic [15:0] exp_word;   // word heard in the frame that pops it
        logic [15:0] exp_next;   // word heard next frame (FIFO empty -> repeat)
    } vec_t;

    vec_t vecs[7];

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] l, r;

        vecs[0] = '{16'h8001, 1'b0, 16'h8001, 16'h8001};
        vecs[1] = '{16'hA5A5, 1'b0, 16'hA5A5, 16'hA5A5};
        vecs[2] = '{16'h7FFF, 1'b1, 16'h0000, 16'h7FFF};
        vecs[3] = '{16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{16'h0001, 1'b0, 16'h0001, 16'h0001};
        vecs[5] = '{16'h1234, 1'b1, 16'h0000, 16'h1234};
        vecs[6] = '{16'h8000, 1'b0, 16'h8000, 16'h8000};

        // Reset and free-running timing with no pushes
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({bclk, lrck, sdata, level, ovf, unf}), 32'd0);
        rst_n = 1'b1;
        wait_abs(3);   check("bclk_low_c3", 32'(bclk), 32'd0);
        wait_abs(4);   check("bclk_high_c4", 32'(bclk), 32'd1);
        wait_abs(7);   check("unf_before_pop", 32'(unf), 32'd0);
        wait_abs(8);   check("unf_after_pop", 32'(unf), 32'd1);
                       check("data_zero_slot1", 32'(sdata), 32'd0);
        wait_abs(127); check("lrck_low_c127", 32'(lrck), 32'd0);
        wait_abs(128); check("lrck_high_c128", 32'(lrck), 32'd1);
        wait_abs(255); check("lrck_high_c255", 32'(lrck), 32'd1);
        wait_abs(256); check("lrck_low_c256", 32'(lrck), 32'd0);

        // Table: one push per vector, frame decoded, then the repeat frame
        wait_ph(8);
        for (int j = 0; j < 7; j++) begin
            wait_ph(20);
            mute = vecs[j].mute;
            push(vecs[j].sample);
            check("vec_level_after_push", 32'(level), 32'd1);
            wait_ph(8);
            mute = 1'b0;
            check("vec_level_after_pop", 32'(level), 32'd0);
            decode_frame(l, r);
            check("vec_left", 32'(l), 32'(vecs[j].exp_word));
            check("vec_right", 32'(r), 32'(vecs[j].exp_word));
            decode_frame(l, r);
            check("vec_next_left", 32'(l), 32'(vecs[j].exp_next));
            check("vec_next_right", 32'(r), 32'(vecs[j].exp_next));
            check("vec_underflow", 32'(unf), 32'd1);
        end

        // Flag clear, and set winning over a simultaneous clear
        wait_ph(100);
        pulse_clear();
        check("clear_unf", 32'(unf), 32'd0);
        check("clear_ovf", 32'(ovf), 32'd0);
        wait_ph(7);
        pulse_clear();
        check("set_beats_clear", 32'(unf), 32'd1);

        // Overflow: five pushes in one frame into a depth-4 FIFO
        wait_ph(10);
        pulse_clear();
        check("ovf_pre_unf", 32'(unf), 32'd0);
        wait_ph(20); push(16'h0001);
        wait_ph(30); push(16'h0002);
        wait_ph(40); push(16'h0003);
        wait_ph(50); push(16'h0004);
        check("full_level", 32'(level), 32'd4);
        check("full_no_ovf", 32'(ovf), 32'd0);
        wait_ph(60); push(16'h0005);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag", 32'(ovf), 32'd1);
        wait_ph(8);
        check("ovf_level_after_pop", 32'(level), 32'd3);
        expect_frame("ovf_w1", 16'h0001);
        expect_frame("ovf_w2", 16'h0002);
        expect_frame("ovf_w3", 16'h0003);
        expect_frame("ovf_w4", 16'h0004);

        // Full FIFO with a push on the pop edge: both happen, no overflow
        wait_ph(10);
        pulse_clear();
        wait_ph(20); push(16'h1111);
        wait_ph(30); push(16'h2222);
        wait_ph(40); push(16'h3333);
        wait_ph(50); push(16'h4444);
        wait_ph(7);  push(16'h5555);
        check("fullpop_level", 32'(level), 32'd4);
        check("fullpop_no_ovf", 32'(ovf), 32'd0);
        expect_frame("fullpop_w1", 16'h1111);
        expect_frame("fullpop_w2", 16'h2222);
        expect_frame("fullpop_w3", 16'h3333);
        expect_frame("fullpop_w4", 16'h4444);
        expect_frame("fullpop_w5", 16'h5555);

        // Empty FIFO with a push on the pop edge: underflow, no bypass
        wait_ph(10);
        pulse_clear();
        wait_ph(7);  push(16'h6666);
        check("emptypop_level", 32'(level), 32'd1);
        check("emptypop_unf", 32'(unf), 32'd1);
        expect_frame("emptypop_repeat", 16'h5555);
        expect_frame("emptypop_new", 16'h6666);

        // Reset in the middle of a frame
        wait_ph(100); push(16'h0ABC);
        push(16'h0DEF);
        wait_ph(162);
        check("pre_reset_level", 32'(level), 32'd2);
        check("pre_reset_lrck", 32'(lrck), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs", 32'({bclk, lrck, sdata, level, ovf, unf}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_abs(127); check("post_reset_lrck_low", 32'(lrck), 32'd0);
        wait_abs(128); check("post_reset_lrck_high", 32'(lrck), 32'd1);

        // Randomized traffic at three push rates, checked by the model
        for (int seg = 0; seg < 6; seg++) begin
            int rate;
            rate = (seg % 3 == 0) ? 60 : ((seg % 3 == 1) ? 256 : 700);
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                sample_in    = 16'($urandom);
                sample_valid = ($urandom_range(0, rate - 1) == 0);
                clear_flags  = ($urandom_range(0, 399) == 0);
                if ($urandom_range(0, 299) == 0) mute = ~mute;
            end
        end
        @(negedge clk);
        sample_valid = 1'b0;
        clear_flags  = 1'b0;
        mute         = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
